// File: rtl/vp_dispatch_pkg.sv
// Shared dispatch definitions: execution unit codes, unit-field geometry, default BRAM read latency.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
`ifndef COMMON_BRAM_DELAY
`define COMMON_BRAM_DELAY 2
`endif

// MSB position of the 2-bit unit field in an instruction word of width dw
`define VP_UNIT_MSB(dw) ((dw) - 1)

package vp_dispatch_pkg;

  localparam int UNIT_FIELD_W = 2;

  typedef enum logic [UNIT_FIELD_W-1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_MEM = 2'd2,
    UNIT_BAR = 2'd3
  } unit_e;

endpackage

// File: rtl/dispatch_buf.sv
// Circular instruction buffer with occupancy count and combinational head word.
// Latency: a word written at an edge is visible at the head in the following cycle.
// Backpressure: none internally; the writer's credit accounting guarantees it never overflows.
module dispatch_buf #(
  parameter int DWIDTH    = 64,
  parameter int BUF_DEPTH = 3,
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int OW = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_vld,
  input  logic [DWIDTH-1:0] wr_dat,
  input  logic              consume,
  output logic [OW-1:0]     occ,
  output logic [DWIDTH-1:0] head
);

  logic [DWIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy tracking; a clear empties the buffer and rewinds both pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_vld)  wr_ptr <= ptr_inc(wr_ptr);
      if (consume) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_vld, consume})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: ;
      endcase
    end
  end

  // Storage array; no reset needed since occ gates every read
  always_ff @(posedge clk) begin
    if (wr_vld && !clr) mem[wr_ptr] <= wr_dat;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/iqueue_dispatch.sv
// Pops the instruction queue, absorbs its read latency in a credit-sized buffer, issues the head to ALU/MUL/MEM.
// Latency: pop to o_inst_valid is COMMON_BRAM_DELAY+1 cycles; one issue per cycle when the target unit is ready.
// Backpressure: a stalled unit holds the head; pops stop once buffered + in-flight words fill BUF_DEPTH.
// Build option IQDISP_BARRIER_EN: unit code 3 becomes a barrier waiting for all units idle (else it is dropped with o_err).
module iqueue_dispatch
  import vp_dispatch_pkg::*;
#(
  parameter int DWIDTH            = 64,
  parameter int COMMON_BRAM_DELAY = `COMMON_BRAM_DELAY,
  parameter int BUF_DEPTH         = COMMON_BRAM_DELAY + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_q_empty,
  output logic              o_q_pop,
  input  logic [DWIDTH-1:0] i_q_data,
  input  logic              i_flush,
  output logic [2:0]        o_inst_valid,
  output logic [DWIDTH-1:0] o_inst,
  input  logic [2:0]        i_unit_ready,
`ifdef IQDISP_BARRIER_EN
  input  logic [2:0]        i_unit_idle,
`endif
  output logic              o_err,
  output logic              o_busy
);

  localparam int L  = COMMON_BRAM_DELAY;
  localparam int OW = $clog2(BUF_DEPTH + 1);

  logic [OW-1:0]     occ;
  logic [DWIDTH-1:0] head;
  logic [L-1:0]      inflight;
  logic              ret_vld;
  logic              buf_nonempty;
  logic              consume;
  logic              drop_illegal;
  unit_e             head_unit;

  assign ret_vld      = inflight[L-1];
  assign buf_nonempty = (occ != '0);
  assign head_unit    = unit_e'(head[`VP_UNIT_MSB(DWIDTH) -: UNIT_FIELD_W]);
  assign o_inst       = buf_nonempty ? head : '0;

  dispatch_buf #(
    .DWIDTH    (DWIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (i_flush),
    .wr_vld  (ret_vld && !i_flush),
    .wr_dat  (i_q_data),
    .consume (consume),
    .occ     (occ),
    .head    (head)
  );

  // Head decode: present normal words to their unit, retire code-3 words without issuing them
  always_comb begin
    o_inst_valid = '0;
    consume      = 1'b0;
    drop_illegal = 1'b0;
    if (buf_nonempty && !i_flush) begin
      if (head_unit == UNIT_BAR) begin
`ifdef IQDISP_BARRIER_EN
        consume = (i_unit_idle == 3'b111);
`else
        consume      = 1'b1;
        drop_illegal = 1'b1;
`endif
      end else begin
        o_inst_valid = 3'b001 << head_unit;
        consume      = |(o_inst_valid & i_unit_ready);
      end
    end
  end

  // Credit check: buffered + in-flight words, less the head leaving now, must leave a free slot; quiet while in reset
  always_comb begin
    o_q_pop = 1'b0;
    if (rst_n && !i_q_empty && !i_flush)
      o_q_pop = (int'(occ) + $countones(inflight) - int'(consume)) < BUF_DEPTH;
  end

  // Read-latency tracker: bit 0 marks a pop just issued, the top bit marks data arriving this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       inflight <= '0;
    else if (i_flush) inflight <= '0;
    else              inflight <= (inflight << 1) | L'(o_q_pop);
  end

  // Registered status: drop pulse and activity flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err  <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      o_err  <= drop_illegal;
      o_busy <= buf_nonempty || (|inflight);
    end
  end

endmodule

// File: doc/iqueue_dispatch.md
# iqueue_dispatch

Dispatch stage directly downstream of the sequencer instruction queue. It pops instruction words from the BRAM-backed queue and absorbs the queue's fixed read latency in a small credit-controlled buffer. It routes each instruction to one of three execution units over a valid/ready handshake, and sustains one instruction per cycle when the target unit is ready.

## Interface
- DWIDTH, 64: instruction word width; unit field is bits [DWIDTH-1 -: 2]
- COMMON_BRAM_DELAY, `COMMON_BRAM_DELAY`: queue read latency L in cycles, L ≥ 1
- BUF_DEPTH, COMMON_BRAM_DELAY+1: buffer entries, ≥ L+1
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_q_empty  in  1  queue empty
- o_q_pop  out  1  queue pop request
- i_q_data  in  DWIDTH  queue read data, valid L cycles after o_q_pop
- i_flush  in  1  discard buffered and in-flight instructions
- o_inst_valid  out  3  one-hot, per-unit valid
- o_inst  out  DWIDTH  head instruction, shared by all units
- i_unit_ready  in  3  per-unit ready
- i_unit_idle  in  3  per-unit idle; present only with IQDISP_BARRIER_EN
- o_err  out  1  one-cycle pulse when an illegal code-3 word is dropped
- o_busy  out  1  buffer non-empty or reads in flight

## Operation
- In-flight tracker: L-bit valid shift register; bit 0 is set on o_q_pop, and bit L-1 marks i_q_data as valid this cycle.
- Credit rule: o_q_pop = !i_q_empty && !i_flush && (occ + inflight − issue) < BUF_DEPTH, where issue is a head consumption this cycle.
- On a returning valid, i_q_data is written to the buffer tail. The buffer is a circular FIFO with $clog2(BUF_DEPTH) pointers that wrap at BUF_DEPTH.
- Head decode uses unit field u:
  - u=0..2: o_inst_valid[u] = buffer non-empty. The handshake completes when i_unit_ready[u]; the head is then consumed.
  - u=3: handled per Configuration.
- Valid is held stable with o_inst unchanged until handshake completion. Ready may toggle freely.
- Simultaneous write and consume: occ is unchanged, and both pointers advance.
- i_flush (one cycle):
  - clears the buffer (occ=0) and zeroes the in-flight register, so data returning from earlier pops is dropped;
  - suppresses o_q_pop and o_inst_valid in that cycle.
- Reset: all outputs 0, occ=0, pointers=0, in-flight=0.

## Timing
- Pop at cycle t → data valid at t+L → buffered at the t+L edge → o_inst_valid high at t+L+1.
- Minimum latency from pop to issue: L+1 cycles.
- Throughput is one issue per cycle with BUF_DEPTH ≥ L+1 and the target unit always ready.
- With the queue non-empty and units stalled, at most BUF_DEPTH pops are outstanding; the buffer never overflows.
- o_err and o_busy are registered; o_err pulses in the cycle after the drop.
- Reset is asynchronous on assertion; all state is sampled on the rising edge of clk after deassertion.

## Configuration
- IQDISP_BARRIER_EN defined:
  - u=3 is a barrier. It is never presented on o_inst_valid.
  - It is consumed silently in the first cycle with i_unit_idle == 3'b111.
  - Following instructions stall behind it.
- Undefined:
  - u=3 is illegal. It is consumed in the cycle it reaches the head, not issued, and o_err pulses.
  - The i_unit_idle port is absent.

## Structure
- Shared package vp_dispatch_pkg holds:
  - unit codes UNIT_ALU=0, UNIT_MUL=1, UNIT_MEM=2, UNIT_BAR=3
  - UNIT_FIELD_W=2 and the unit-field position macro
- Sub-module dispatch_buf: a parameterised circular FIFO (DWIDTH, BUF_DEPTH) providing occ, head, write and consume.
- Credit logic, in-flight register and decode live in the top level.

## Test plan
- L=2, BUF_DEPTH=3, queue holding 5 words for u=0 with unit 0 always ready → first pop at cycle 1, first issue at cycle 4, then one issue per cycle; issue order equals push order.
- i_unit_ready=0 with 10 words queued → exactly 3 pops, then o_q_pop held 0; the 3 buffered words are released in order when ready rises.
- i_flush asserted 1 cycle after a pop, with 2 words in flight and 1 buffered → no word issued; the next pop's data is the first issued; o_busy=0 two cycles after the flush.
- Word with u=1 at the head, i_unit_ready=3'b101 → o_inst_valid=3'b010 held for 5 cycles with o_inst stable; issue occurs when ready[1] rises.
- Barrier (with macro) followed by a u=0 word, i_unit_idle=3'b011 for 4 cycles, then 3'b111 → barrier consumed in the cycle idle reaches 3'b111; the u=0 word is valid the next cycle.
- Without macro, a u=3 word between two u=2 words → one o_err pulse; only the two u=2 words are issued.
- rst_n pulled low mid-stream → all outputs 0 immediately; after release, the first pop occurs only once i_q_empty=0.
